onehot_decoder_ctrl: RTL



---
 rtl/onehot_decoder_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/onehot_decoder_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | onehot_decoder_ctrl: registered binary-to-one-hot decoder with enable,   |
// | load strobe and a self-running scan mode with programmable dwell.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+

module onehot_decoder_ctrl #(
  parameter int N    = 3,
  parameter int HOLD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 mode,
  input  logic                 load,
  input  logic [N-1:0]         a,
  output logic [(1<<N)-1:0]    y,
  output logic [N-1:0]         idx,
  output logic                 valid,
  output logic                 wrap
);

  localparam int              C_W          = 1 << N;
  localparam int              C_CW         = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [C_CW-1:0] C_CNT_LAST   = C_CW'(HOLD - 1);
  localparam logic [N-1:0]    C_IDX_LAST   = '1;
  localparam logic [0:0]      C_MODE_SCAN  = 1'b1;

  logic [C_W-1:0]  y_d,     y_q;
  logic [N-1:0]    idx_d,   idx_q;
  logic [C_CW-1:0] cnt_d,   cnt_q;
  logic            valid_d, valid_q;
  logic            wrap_d,  wrap_q;

  always_comb begin
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    wrap_d  = 1'b0;

    if (!en) begin
      // Blanking keeps idx and cnt so a later scan resumes where it stopped.
      valid_d = 1'b0;
    end else if (mode == C_MODE_SCAN) begin
      valid_d = 1'b1;
      if (load) begin
        idx_d = a;
        cnt_d = '0;
      end else if (cnt_q == C_CNT_LAST) begin
        cnt_d  = '0;
        idx_d  = idx_q + 1'b1;
        wrap_d = (idx_q == C_IDX_LAST);
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
      if (load) begin
        idx_d   = a;
        valid_d = 1'b1;
      end
    end

    // y is decoded from next-state values so the flop output is the one-hot itself.
    y_d = valid_d ? (C_W'(1) << idx_d) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      y_q     <= y_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
    end
  end

  assign y     = y_q;
  assign idx   = idx_q;
  assign valid = valid_q;
  assign wrap  = wrap_q;

endmodule

`default_nettype wire
